// File: rtl/serial_boot_loader_if.sv
// Byte-fetch and memory-write handshake between the boot loader, the UART receiver and memory.
// The loader side is the master; the receiver/memory side is the slave.
interface serial_boot_loader_if #(
  parameter int unsigned ABITS = 9
);
  logic             rx_start;
  logic             rx_wait;
  logic [7:0]       rx_data;
  logic             mem_wr;
  logic             mem_wait;
  logic [ABITS-1:0] mem_addr;
  logic [15:0]      mem_wdata;

  modport master (
    output rx_start, mem_wr, mem_addr, mem_wdata,
    input  rx_wait, rx_data, mem_wait
  );

  modport slave (
    input  rx_start, mem_wr, mem_addr, mem_wdata,
    output rx_wait, rx_data, mem_wait
  );
endinterface

// File: rtl/serial_boot_loader.sv
// Serial boot loader: parses MAGIC/CNT/data/CKSUM frames from the UART, writes 16-bit words
// from address 0 and releases the CPU only after the checksum verifies.
module serial_boot_loader #(
  parameter int unsigned ABITS = 9,
  parameter logic [7:0]  MAGIC = 8'hED
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  serial_boot_loader_if.master  bus,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [16:0]      MaxWords = 17'(1 << ABITS);
  localparam logic [ABITS:0]   RemOne   = 1;
  localparam logic [ABITS-1:0] AddrOne  = 1;

  typedef enum logic [2:0] {StRxReq, StRxWait, StWrite, StDone, StErr} state_e;
  typedef enum logic [2:0] {PhHunt, PhCntH, PhCntL, PhDatH, PhDatL, PhCksum} phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic             rx_start_q, rx_start_d;
  logic             mem_wr_q, mem_wr_d;
  logic [ABITS-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       cnt_hi_q, cnt_hi_d;
  logic [ABITS:0]   remain_q, remain_d;
  logic [7:0]       sum_q, sum_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [16:0]      cnt_w;

  assign cnt_w = {1'b0, cnt_hi_q, bus.rx_data};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRxReq;
      phase_q     <= PhHunt;
      rx_start_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hi_q        <= '0;
      cnt_hi_q    <= '0;
      remain_q    <= '0;
      sum_q       <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rx_start_q  <= rx_start_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hi_q        <= hi_d;
      cnt_hi_q    <= cnt_hi_d;
      remain_q    <= remain_d;
      sum_q       <= sum_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rx_start_d  = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hi_d        = hi_q;
    cnt_hi_d    = cnt_hi_q;
    remain_d    = remain_q;
    sum_d       = sum_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      StRxReq: begin
        rx_start_d = 1'b1;
        state_d    = StRxWait;
      end
      StRxWait: begin
        // rx_start_q is high only in the first wait cycle, when rx_wait is not yet meaningful
        if (!rx_start_q && !bus.rx_wait) begin
          state_d = StRxReq;
          unique case (phase_q)
            PhHunt: begin
              if (bus.rx_data == MAGIC) begin
                err_d      = 1'b0;
                sum_d      = '0;
                mem_addr_d = '0;
                phase_d    = PhCntH;
              end
            end
            PhCntH: begin
              cnt_hi_d = bus.rx_data;
              phase_d  = PhCntL;
            end
            PhCntL: begin
              if (cnt_w > MaxWords) begin
                state_d = StErr;
              end else if (cnt_w == '0) begin
                phase_d = PhCksum;
              end else begin
                remain_d = cnt_w[ABITS:0];
                phase_d  = PhDatH;
              end
            end
            PhDatH: begin
              hi_d    = bus.rx_data;
              sum_d   = sum_q + bus.rx_data;
              phase_d = PhDatL;
            end
            PhDatL: begin
              mem_wdata_d = {hi_q, bus.rx_data};
              sum_d       = sum_q + bus.rx_data;
              mem_wr_d    = 1'b1;
              state_d     = StWrite;
            end
            PhCksum: begin
              if (bus.rx_data == sum_q) begin
                state_d    = StDone;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
              end else begin
                state_d = StErr;
              end
            end
            default: phase_d = PhHunt;
          endcase
        end
      end
      StWrite: begin
        if (!bus.mem_wait) begin
          mem_wr_d = 1'b0;
          remain_d = remain_q - RemOne;
          state_d  = StRxReq;
          // The last word leaves the address in place so a full image never wraps it
          if (remain_q == RemOne) begin
            phase_d = PhCksum;
          end else begin
            mem_addr_d = mem_addr_q + AddrOne;
            phase_d    = PhDatH;
          end
        end
      end
      StDone: ;
      StErr: begin
        err_d      = 1'b1;
        mem_addr_d = '0;
        phase_d    = PhHunt;
        state_d    = StRxReq;
      end
      default: state_d = StRxReq;
    endcase
  end

  assign bus.rx_start  = rx_start_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold_o    = cpu_hold_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_serial_boot_loader.sv
// Bench for serial_boot_loader: byte-stream frame model, UART/memory responders and a
// per-cycle compare process.
module tb_serial_boot_loader;
  localparam int unsigned ABITS = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_hold, done, err;

  always #5 clk = ~clk;

  serial_boot_loader_if #(.ABITS(ABITS)) bus ();

  serial_boot_loader #(.ABITS(ABITS), .MAGIC(8'hED)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .cpu_hold_o(cpu_hold),
    .done_o    (done),
    .err_o     (err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rx_q[$];
  logic [7:0] stream[$];
  int exp_addr[$];
  int exp_data[$];
  bit exp_done, exp_err;
  int wr_log_addr[$];
  int wr_log_data[$];
  int first_hold = 0;
  int gen = 0;
  int stall_first = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Frame model over every byte sent since reset: expected writes and final status.
  task automatic model();
    int i, n, cnt, sum;
    bit cut;
    i = 0; n = stream.size(); cut = 0;
    exp_addr.delete(); exp_data.delete(); exp_done = 0; exp_err = 0;
    while (i < n && !exp_done && !cut) begin
      if (stream[i] != 8'hED) begin i++; continue; end
      i++; exp_err = 0;
      if (i + 2 > n) begin cut = 1; continue; end
      cnt = int'(stream[i]) * 256 + int'(stream[i+1]);
      i += 2;
      if (cnt > (1 << ABITS)) begin exp_err = 1; continue; end
      sum = 0;
      for (int w = 0; w < cnt && !cut; w++) begin
        if (i + 2 > n) cut = 1;
        else begin
          exp_addr.push_back(w);
          exp_data.push_back(int'(stream[i]) * 256 + int'(stream[i+1]));
          sum += int'(stream[i]) + int'(stream[i+1]);
          i += 2;
        end
      end
      if (cut || i >= n) begin cut = 1; continue; end
      if ((sum % 256) == int'(stream[i])) exp_done = 1; else exp_err = 1;
      i++;
    end
  endtask

  function automatic int nib(input byte c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return 0;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    stream.push_back(b);
    rx_q.push_back(b);
  endtask

  task automatic send_hex(input string s);
    int hi;
    byte c;
    hi = -1;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h20) continue;
      if (hi < 0) hi = nib(c);
      else begin
        push_byte(8'(hi * 16 + nib(c)));
        hi = -1;
      end
    end
    model();
  endtask

  task automatic send_words(input int cnt);
    logic [15:0] w;
    logic [7:0]  sum;
    sum = 8'h00;
    push_byte(8'hED);
    push_byte(8'(cnt >> 8));
    push_byte(8'(cnt));
    for (int i = 0; i < cnt; i++) begin
      w = 16'((i * 37 + 5) & 16'hFFFF);
      push_byte(w[15:8]);
      push_byte(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
    end
    push_byte(sum);
    model();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    gen++;
    rx_q.delete(); stream.delete(); exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 0; stall_first = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_rx_start", bus.rx_start, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rx_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("rx_bytes_consumed", rx_q.size(), 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic verify(input string tag);
    check({tag, "_done"}, done, int'(exp_done));
    check({tag, "_err"}, err, int'(exp_err));
    check({tag, "_cpu_hold"}, cpu_hold, int'(!exp_done));
    check({tag, "_writes"}, wr_log_addr.size(), exp_addr.size());
  endtask

  function automatic int log_data(input int k);
    return (k < wr_log_data.size()) ? wr_log_data[k] : -1;
  endfunction

  function automatic int log_addr(input int k);
    return (k < wr_log_addr.size()) ? wr_log_addr[k] : -1;
  endfunction

  // UART receiver: raise rx_wait on rx_start, present the next queued byte two cycles later.
  initial begin : uart
    int g;
    bus.rx_wait = 1'b1;
    bus.rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.rx_start) begin
        g = gen;
        bus.rx_wait = 1'b1;
        repeat (2) @(posedge clk);
        while (rx_q.size() == 0 && g == gen) @(posedge clk);
        #1;
        if (g == gen) begin
          bus.rx_data = rx_q.pop_front();
          bus.rx_wait = 1'b0;
        end
      end
    end
  end

  // Memory: stall the first write after reset for stall_first cycles.
  initial begin : mem
    int left;
    bit started;
    left = 0; started = 0;
    bus.mem_wait = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        started = 0; left = 0; bus.mem_wait = 1'b0;
      end else if (bus.mem_wr) begin
        if (!started) begin started = 1; left = stall_first; end
        if (left > 0) begin bus.mem_wait = 1'b1; left--; end
        else bus.mem_wait = 1'b0;
      end else begin
        bus.mem_wait = 1'b0;
      end
    end
  end

  initial begin : cmp
    int hold, h_addr, h_data, k;
    hold = 0; h_addr = 0; h_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; first_hold = 0;
        wr_log_addr.delete(); wr_log_data.delete();
      end else begin
        check("cpu_hold_vs_done", cpu_hold, int'(!done));
        check("done_err_exclusive", done & err, 0);
        if (done) check("rx_start_after_done", bus.rx_start, 0);
        if (bus.mem_wr) begin
          if (hold == 0) begin
            h_addr = bus.mem_addr; h_data = bus.mem_wdata;
          end else begin
            check("addr_held", bus.mem_addr, h_addr);
            check("data_held", bus.mem_wdata, h_data);
          end
          hold++;
          if (!bus.mem_wait) begin
            k = wr_log_addr.size();
            if (k == 0) first_hold = hold;
            if (k < exp_addr.size()) begin
              check("write_addr", bus.mem_addr, exp_addr[k]);
              check("write_data", bus.mem_wdata, exp_data[k]);
            end else begin
              check("write_count", k + 1, exp_addr.size());
            end
            wr_log_addr.push_back(bus.mem_addr);
            wr_log_data.push_back(bus.mem_wdata);
            hold = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation still running, limit 5ms");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    do_reset();

    // Three words; checksum of 12 34 AB CD 00 01 is BF
    send_hex("ED 00 03 12 34 AB CD 00 01 BF");
    drain();
    verify("t1");
    check("t1_w0_data", log_data(0), 'h1234);
    check("t1_w1_data", log_data(1), 'hABCD);
    check("t1_w2_data", log_data(2), 'h0001);
    check("t1_w2_addr", log_addr(2), 2);
    check("t1_cpu_released", cpu_hold, 0);

    do_reset();
    send_hex("ED 00 01 11 22 00");
    drain();
    verify("t2_bad");
    check("t2_bad_err_lit", err, 1);
    send_hex("ED 00 01 11 22 33");
    drain();
    verify("t2_good");
    check("t2_good_addr", log_addr(1), 0);
    check("t2_good_data", log_data(1), 'h1122);

    do_reset();
    send_hex("55 AA 00 ED 00 01 00 05 05");
    drain();
    verify("t3");
    check("t3_data", log_data(0), 'h0005);

    do_reset();
    send_hex("ED 00 00 00");
    drain();
    verify("t4_empty_ok");
    do_reset();
    send_hex("ED 00 00 01");
    drain();
    verify("t4_empty_bad");

    do_reset();
    send_hex("ED 02 01");
    drain();
    verify("t5_oversize");
    check("t5_oversize_err_lit", err, 1);
    send_words(512);
    drain();
    verify("t5_full");
    check("t5_last_addr", log_addr(511), 'h1FF);
    check("t5_first_addr", log_addr(0), 0);

    do_reset();
    stall_first = 3;
    // Checksum of BE EF 12 34 is F3
    send_hex("ED 00 02 BE EF 12 34 F3");
    drain();
    verify("t6_stall");
    check("t6_hold_cycles", first_hold, 4);

    do_reset();
    stall_first = 8;
    send_hex("ED 00 02 BE EF 12 34 F3");
    n = 0;
    while (!bus.mem_wr && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_write_started", bus.mem_wr, 1);
    do_reset();
    send_hex("ED 00 01 00 05 05");
    drain();
    verify("t6_after_rst");
    check("t6_after_rst_addr", log_addr(0), 0);
    check("t6_after_rst_data", log_data(0), 'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
